// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl -- push/pop FIFO sequencer in front of the 16 x 8 single-port
// register-file RAM. It keeps the circular-buffer state, arbitrates one RAM
// operation per cycle and registers the byte read back from the RAM.
//
// Optional feature: define RAMFIFO_CLEAR_SWEEP_EN to make `clear` start a
// 16-cycle sweep that writes 8'h00 to every RAM address (busy high meanwhile).
// Without it, `clear` only resets pointers/count/prio and busy is tied low.
//
// Ports
//   clk, reset (async, active-low), clear (sync flush, active-high)
//   push_valid/push_data/push_ready : producer handshake
//   pop_req/pop_ready               : consumer handshake
//   pop_data/pop_valid              : registered popped byte + 1-cycle strobe
//   full, empty, count[4:0]         : occupancy from registered count
//   busy                            : clear sweep in progress
//   ram_addr/ram_data_in/ram_write/ram_read : RAM strobes
//   ram_read_out                    : RAM read data (combinational)
module ram_fifo_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       push_valid,
  input  logic [7:0] push_data,
  output logic       push_ready,
  input  logic       pop_req,
  output logic       pop_ready,
  output logic [7:0] pop_data,
  output logic       pop_valid,
  output logic       full,
  output logic       empty,
  output logic [4:0] count,
  output logic       busy,
  output logic [3:0] ram_addr,
  output logic [7:0] ram_data_in,
  output logic       ram_write,
  output logic       ram_read,
  input  logic [7:0] ram_read_out
);

  logic [3:0] wr_ptr, rd_ptr;
  logic       prio;
  logic       push_elig, pop_elig, push_grant, pop_grant;
  logic       open_q;   // controller may accept traffic this cycle
  logic       clear_take;

`ifdef RAMFIFO_CLEAR_SWEEP_EN
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  state_t     state_q, state_d;
  logic [3:0] sweep_q;

  assign busy = (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear) state_d = CLEAR;
      CLEAR:   if (sweep_q == 4'hF) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == CLEAR) sweep_q <= sweep_q + 4'd1;
      else                  sweep_q <= '0;
    end
  end
`else
  assign busy = 1'b0;
`endif

  assign full  = (count == 5'd16);
  assign empty = (count == 5'd0);

  // Gating with reset keeps the RAM strobes low for the whole time reset is
  // held, and gating with clear keeps a same-cycle push/pop from looking
  // accepted when the flush wins.
  assign open_q     = reset && !busy && !clear;
  assign clear_take = clear && !busy;

  assign push_elig  = open_q && push_valid && !full;
  assign pop_elig   = open_q && pop_req && !empty;
  assign push_grant = push_elig && (!pop_elig || !prio);
  assign pop_grant  = pop_elig && (!push_elig || prio);

  assign push_ready = open_q && !full && !pop_grant;
  assign pop_ready  = open_q && !empty && !push_grant;

  always_comb begin
    ram_addr    = rd_ptr;
    ram_data_in = push_data;
    ram_write   = 1'b0;
    ram_read    = 1'b0;
    if (push_grant) begin
      ram_addr  = wr_ptr;
      ram_write = 1'b1;
    end else if (pop_grant) begin
      ram_read  = 1'b1;
    end
`ifdef RAMFIFO_CLEAR_SWEEP_EN
    if (state_q == CLEAR) begin
      ram_addr    = sweep_q;
      ram_data_in = '0;
      ram_write   = reset;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      prio      <= 1'b0;
      pop_valid <= 1'b0;
      pop_data  <= '0;
    end else begin
      pop_valid <= pop_grant;
      if (pop_grant) pop_data <= ram_read_out;
      if (clear_take) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        prio   <= 1'b0;
      end else begin
        if (push_grant) wr_ptr <= wr_ptr + 4'd1;
        if (pop_grant)  rd_ptr <= rd_ptr + 4'd1;
        case ({push_grant, pop_grant})
          2'b10:   count <= count + 5'd1;
          2'b01:   count <= count - 5'd1;
          default: count <= count;
        endcase
        if (push_elig && pop_elig) prio <= ~prio;
      end
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl with a behavioural 16 x 8 RAM attached.
module tb_ram_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       push_valid = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       pop_req = 1'b0;
  logic       push_ready, pop_ready, pop_valid, full, empty, busy;
  logic       ram_write, ram_read;
  logic [7:0] pop_data, ram_data_in, ram_read_out;
  logic [4:0] count;
  logic [3:0] ram_addr;

  ram_fifo_ctrl dut (
    .clk(clk), .reset(reset), .clear(clear),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_req(pop_req), .pop_ready(pop_ready),
    .pop_data(pop_data), .pop_valid(pop_valid),
    .full(full), .empty(empty), .count(count), .busy(busy),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_write(ram_write), .ram_read(ram_read), .ram_read_out(ram_read_out)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  assign ram_read_out = mem[ram_addr];
  always @(posedge clk) if (ram_write) mem[ram_addr] <= ram_data_in;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] data; int cyc; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] model_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every pop strobe must match the oldest expected byte and arrive
  // exactly one cycle after its accept.
  always @(negedge clk) begin
    if (pop_valid) begin
      if (exp_q.size() == 0) begin
        chk("pop_valid_unexpected", pop_valid, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pop_data", pop_data, e.data);
        chk("pop_latency_cycle", cyc, e.cyc);
      end
    end
    if (ram_write || ram_read) chk("ram_single_op", ram_write && ram_read, 0);
  end

  // One cycle of stimulus: inputs are already driven; checks expected ready
  // values (-1 = don't care) and records accepted transfers.
  task automatic step(input int epr, input int eqr);
    exp_t e;
    @(negedge clk);
    if (epr >= 0) chk("push_ready", push_ready, epr);
    if (eqr >= 0) chk("pop_ready", pop_ready, eqr);
    if (pop_req && pop_ready) begin
      if (model_q.size() == 0) begin
        chk("pop_ready_when_model_empty", pop_ready, 0);
      end else begin
        e.data = model_q.pop_front();
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
      end
    end
    if (push_valid && push_ready) model_q.push_back(push_data);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h5A;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_pop_data", pop_data, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_ram_write", ram_write, 0);
    chk("rst_ram_read", ram_read, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Fill 0x10..0x1F, one push per cycle
    for (int i = 0; i < 16; i++) begin
      push_valid = 1'b1;
      push_data  = 8'h10 + 8'(i);
      step(1, -1);
    end
    push_valid = 1'b0;
    @(negedge clk);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_push_ready", push_ready, 0);
    @(posedge clk); #1;

    // Full: push is ineligible, pop wins
    push_valid = 1'b1; push_data = 8'hEE; pop_req = 1'b1;
    step(0, 1);
    push_valid = 1'b0;
    for (int i = 0; i < 15; i++) step(-1, 1);
    pop_req = 1'b0;
    @(negedge clk);
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    @(posedge clk); #1;

    // Wrap-around: push 3 / pop 3, eight rounds
    for (int r = 0; r < 8; r++) begin
      push_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin
        push_data = 8'h40 + 8'(r * 3 + j);
        step(1, -1);
      end
      push_valid = 1'b0;
      pop_req = 1'b1;
      for (int j = 0; j < 3; j++) step(-1, 1);
      pop_req = 1'b0;
    end
    @(negedge clk);
    chk("wrap_count", count, 0);
    @(posedge clk); #1;

    // Contention from count = 4: push, pop, push, pop
    push_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_data = 8'h60 + 8'(k);
      step(1, -1);
    end
    pop_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_data = 8'h70 + 8'(k);
      step((k % 2 == 0) ? 1 : 0, (k % 2 == 0) ? 0 : 1);
    end
    push_valid = 1'b0;
    pop_req = 1'b0;
    @(negedge clk);
    chk("contend_count", count, 4);
    @(posedge clk); #1;
    pop_req = 1'b1;
    for (int k = 0; k < 4; k++) step(-1, 1);
    pop_req = 1'b0;

    // Empty edge: push and pop together when empty
    push_valid = 1'b1; push_data = 8'hA5; pop_req = 1'b1;
    step(1, 0);
    push_valid = 1'b0;
    step(-1, 1);
    pop_req = 1'b0;
    @(negedge clk);
    chk("empty_edge_pop_valid", pop_valid, 1);
    chk("empty_edge_pop_data", pop_data, 8'hA5);
    @(posedge clk); #1;

    // Reset mid-traffic, with a pop accepted and its strobe pending
    push_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_data = 8'hB0 + 8'(k);
      step(1, -1);
    end
    push_valid = 1'b0; pop_req = 1'b1;
    @(negedge clk);
    chk("midrst_pop_ready", pop_ready, 1);
    push_valid = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_full", full, 0);
    chk("midrst_pop_valid", pop_valid, 0);
    chk("midrst_ram_write", ram_write, 0);
    @(posedge clk); #1;
    chk("midrst_pop_valid_after_edge", pop_valid, 0);
    model_q.delete();
    push_valid = 1'b0; pop_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Clear from count = 5, with push and pop also requested
    push_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push_data = 8'h80 + 8'(k);
      step(1, -1);
    end
    push_data = 8'hCC; pop_req = 1'b1; clear = 1'b1;
    @(negedge clk);
    chk("clear_cycle_ram_write", ram_write, 0);
    chk("clear_cycle_ram_read", ram_read, 0);
    @(posedge clk); #1;
    clear = 1'b0; pop_req = 1'b0;
    model_q.delete();
`ifdef RAMFIFO_CLEAR_SWEEP_EN
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("sweep_busy", busy, 1);
      chk("sweep_ram_write", ram_write, 1);
      chk("sweep_ram_addr", ram_addr, i);
      chk("sweep_ram_data", ram_data_in, 0);
      chk("sweep_push_ready", push_ready, 0);
      @(posedge clk); #1;
    end
    push_valid = 1'b0;
    @(negedge clk);
    chk("sweep_done_busy", busy, 0);
    for (int i = 0; i < 16; i++) chk("sweep_mem_zero", mem[i], 0);
`else
    push_valid = 1'b0;
    @(negedge clk);
    chk("clear_busy", busy, 0);
`endif
    chk("clear_empty", empty, 1);
    chk("clear_count", count, 0);
    @(posedge clk); #1;

    // Pointers restart at 0 after clear
    push_valid = 1'b1; push_data = 8'h99;
    @(negedge clk);
    chk("post_clear_wr_addr", ram_addr, 0);
    @(posedge clk); #1;
    push_valid = 1'b0;
    model_q.push_back(8'h99);
    pop_req = 1'b1;
    step(-1, 1);
    pop_req = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
# ram_fifo_ctrl

Sequencing front-end for the 16 x 8 register-file RAM: turns a push/pop streaming interface into the RAM's address, data, write and read strobes, and manages the circular buffer state. The block sits directly upstream of the RAM:
- drives `addr_in`, `data_in`, `write` and `read`;
- captures `read_out` back into a registered pop data port.

The RAM's own reset is driven separately. This block never relies on RAM contents after reset.

## Interface
Parameters
- none (depth 16, width 8, fixed by the RAM)

Ports
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous flush request, active-high.
- `push_valid` input 1: producer has a byte on `push_data`.
- `push_data` input 8: byte to store.
- `push_ready` output 1: push accepted this cycle when `push_valid && push_ready`.
- `pop_req` input 1: consumer requests one byte.
- `pop_ready` output 1: pop accepted this cycle when `pop_req && pop_ready`.
- `pop_data` output 8: registered popped byte.
- `pop_valid` output 1: one-cycle strobe; `pop_data` is new.
- `full` output 1: count == 16.
- `empty` output 1: count == 0.
- `count` output 5: occupancy, 0..16.
- `busy` output 1: clear sweep in progress.
- `ram_addr` output 4: to RAM `addr_in`.
- `ram_data_in` output 8: to RAM `data_in`.
- `ram_write` output 1: to RAM `write`.
- `ram_read` output 1: to RAM `read`.
- `ram_read_out` input 8: from RAM `read_out`; valid combinationally while `ram_read` is high.

## Operation
- **State:**
  - `wr_ptr[3:0]`, `rd_ptr[3:0]`; both wrap 15 -> 0.
  - `count[4:0]`.
  - `prio` bit: 0 = push wins next contention.
  - FSM `IDLE` / `CLEAR`.
- **Single-port RAM:** at most one RAM operation per cycle.
- **Eligibility (IDLE):**
  - push eligible = `push_valid && !full`.
  - pop eligible = `pop_req && !empty`.
- **Arbitration:**
  - If only one operation is eligible, it is granted.
  - If both are eligible, the side selected by `prio` is granted and `prio` toggles; the other side sees ready low.
  - `prio` changes only on contention.
- **Ready outputs:** combinational.
  - `push_ready = !full && !busy && !(pop granted)`.
  - `pop_ready = !empty && !busy && !(push granted)`.
- **Push grant:**
  - RAM drive: `ram_addr = wr_ptr`, `ram_data_in = push_data`, `ram_write = 1`.
  - Next edge: `wr_ptr++`, `count++`.
- **Pop grant:**
  - RAM drive: `ram_addr = rd_ptr`, `ram_read = 1`.
  - Next edge: `pop_data <= ram_read_out`, `pop_valid <= 1`, `rd_ptr++`, `count--`.
- **No grant:**
  - `ram_addr = rd_ptr`, `ram_write = 0`, `ram_read = 0`, `ram_data_in = push_data`.
- **Flags:** `full` and `empty` decode from registered `count`.
- **Clear:**
  - `clear` has priority over push and pop in the same cycle; that cycle's push/pop are not granted.
  - See Configuration for the full clear behaviour.

## Timing
- **Reset values:**
  - `wr_ptr = rd_ptr = 0`, `count = 0`, `prio = 0`, state `IDLE`.
  - `empty = 1`, `full = 0`, `pop_valid = 0`, `pop_data = 8'h00`, `busy = 0`.
  - `ram_write = 0`, `ram_read = 0`.
- **Push latency:** data is written at the edge ending the grant cycle. It is poppable from the next cycle.
- **Pop latency:** `pop_data` and `pop_valid` appear one cycle after the accept cycle. `pop_valid` is high for exactly one cycle per accepted pop.
- **Back-to-back:** one push or one pop accepted every cycle. Under sustained contention they alternate 1:1.
- **Full:** a push with `pop_req` also asserted is not possible (push is ineligible); the pop is granted.
- **Empty:** a pop is ineligible; a simultaneous push is granted. The byte is readable the following cycle, not the same cycle.
- **Reset mid-operation:** asynchronous. All state returns to reset values immediately, including abandoning a clear sweep. A pop strobe pending for the next edge is lost.

## Configuration
- **Macro:** `RAMFIFO_CLEAR_SWEEP_EN`.
- **Defined:**
  - `clear` in `IDLE` enters `CLEAR` at the next edge, with pointers, `count` and `prio` zeroed.
  - `CLEAR` runs 16 cycles writing `8'h00` to addresses 0..15: `ram_write = 1`, `ram_addr` = sweep counter.
  - During `CLEAR`: `busy = 1`, `push_ready = pop_ready = 0`, `clear` ignored.
  - After address 15 the FSM returns to `IDLE`.
- **Undefined:**
  - `clear` zeroes pointers, `count` and `prio` at the next edge; RAM contents untouched.
  - `busy` tied 0; `CLEAR` state and sweep counter absent.

## Test plan
- **Reset:** reset low mid-traffic -> `count = 0`, `empty = 1`, `full = 0`, `pop_valid = 0`, `ram_write = 0` immediately.
- **Fill and drain order:** push 0x10..0x1F on 16 consecutive cycles -> `full = 1`, `count = 16`, `push_ready = 0`. Then 16 pops -> `pop_data` = 0x10..0x1F in order, one cycle after each accept; `empty = 1`.
- **Wrap-around:** push 3 / pop 3 repeated eight times (crossing 15 -> 0) -> every pop matches its push; `count` returns to 0.
- **Contention:** with `count = 4`, hold `push_valid` and `pop_req` for 4 cycles -> grants push, pop, push, pop; `count` ends at 4.
- **Empty edge:** when empty, assert push 0xA5 and `pop_req` together -> push granted; pop granted next cycle; `pop_data = 0xA5` the cycle after.
- **Clear with `RAMFIFO_CLEAR_SWEEP_EN`:** from `count = 5`, pulse `clear` -> `busy` high for 16 cycles, ram writes 0x00 to addresses 0..15, then `empty = 1`, `count = 0`. Without the macro -> `empty = 1` one cycle after `clear`, `busy` stays 0.
